timer_apb_slave: RTL and testbench

APB completer (slave) register block of the 8-bit timer; the CPU-side APB master issues apb_write/apb_read transfers against it.
- Decodes TDR (0x00), TCR (0x01), TSR (0x02) and TCNT (0x03).
- Drives the counter core's control levels: load value, load, direction, enable and clock select.
- Captures the counter's overflow/underflow pulses into sticky status flags.
- Sits between the APB bus and the counter/prescaler datapath.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/timer_apb_fsm.sv | 55 +++++
 rtl/timer_apb_slave.sv | 97 +++++++++
 tb/tb_timer_apb_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer APB register block.
package timer_pkg;

  // Register addresses
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bit positions; bits 6 and 3:2 are reserved
  localparam int TCR_LOAD    = 7;
  localparam int TCR_DIR     = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_LSB = 0;
  localparam logic [7:0] TCR_MASK = 8'hB3;

  // TSR bit positions
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Reset values
  localparam logic [7:0] TDR_RST = 8'h00;
  localparam logic [7:0] TCR_RST = 8'h00;
  localparam logic       TSR_RST = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB transfer sequencer: tracks SETUP/ACCESS, inserts wait states and
// raises pready for exactly one cycle per completed transfer.
module timer_apb_fsm #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready
);
  import timer_pkg::*;

  apb_state_t state, state_nxt;
  logic [1:0] wcnt, wcnt_nxt;

  // State and wait counter registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state; pready is the access strobe the top commits on
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pready    = 1'b0;
    case (state)
      // penable without a preceding setup is ignored (stay idle)
      IDLE: if (psel && !penable) state_nxt = SETUP;
      SETUP: begin
        if (!psel) state_nxt = IDLE;
        else if (penable) begin
          state_nxt = ACCESS;
          wcnt_nxt  = 2'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel) state_nxt = IDLE;          // aborted: no strobe
        else if (wcnt != 2'd0) wcnt_nxt = wcnt - 2'd1;
        else begin
          pready    = 1'b1;
          state_nxt = (!penable) ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/timer_apb_slave.sv
// Timer APB register block: TDR/TCR control registers, sticky TSR flags,
// read-only TCNT window and error response for unmapped or illegal access.
module timer_apb_slave #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        tcnt_i,
  input  logic              ovf_set_i,
  input  logic              udf_set_i,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              dir_o,
  output logic              en_o,
  output logic [1:0]        cks_o
);
  import timer_pkg::*;

  logic [7:0] tdr, tcr, rdata;
  logic       ovf, udf;
  logic       err, wr, clr_ovf, clr_udf;

  timer_apb_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pready  (pready)
  );

  // Unmapped address or write to the read-only counter window
  always_comb begin
    err = (paddr > ADDR_W'(ADDR_TCNT)) ||
          (pwrite && (paddr == ADDR_W'(ADDR_TCNT)));
  end

  assign wr      = pready && pwrite && !err;
  assign pslverr = pready && err;
  assign clr_ovf = wr && (paddr == ADDR_W'(ADDR_TSR)) && !pwdata[TSR_OVF];
  assign clr_udf = wr && (paddr == ADDR_W'(ADDR_TSR)) && !pwdata[TSR_UDF];

  // Read mux straight off the register flops so TCNT is sampled in the
  // pready cycle itself
  always_comb begin
    rdata = 8'h00;
    case (paddr)
      ADDR_W'(ADDR_TDR):  rdata = tdr;
      ADDR_W'(ADDR_TCR):  rdata = tcr;
      ADDR_W'(ADDR_TSR):  begin
        rdata[TSR_OVF] = ovf;
        rdata[TSR_UDF] = udf;
      end
      ADDR_W'(ADDR_TCNT): rdata = tcnt_i;
      default:            rdata = 8'h00;
    endcase
  end

  assign prdata = (pready && !pwrite && !err) ? rdata : 8'h00;

  // Control registers; reserved TCR bits are dropped on write
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr <= TDR_RST;
      tcr <= TCR_RST;
    end else if (wr) begin
      if (paddr == ADDR_W'(ADDR_TDR)) tdr <= pwdata;
      if (paddr == ADDR_W'(ADDR_TCR)) tcr <= pwdata & TCR_MASK;
    end
  end

  // Sticky status flags: hardware set beats a write-zero clear
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ovf <= TSR_RST;
      udf <= TSR_RST;
    end else begin
      ovf <= ovf_set_i | (ovf & ~clr_ovf);
      udf <= udf_set_i | (udf & ~clr_udf);
    end
  end

  assign tdr_o  = tdr;
  assign load_o = tcr[TCR_LOAD];
  assign dir_o  = tcr[TCR_DIR];
  assign en_o   = tcr[TCR_EN];
  assign cks_o  = tcr[TCR_CKS_LSB +: 2];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Self-checking bench for timer_apb_slave (WAIT_CYCLES=2): directed plan
// followed by randomized traffic against a transaction-level model.
module tb_timer_apb_slave;
  localparam int WAIT = 2;

  logic       pclk = 1'b0, preset = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00, tcnt_i = 8'h00;
  logic       ovf_set_i = 1'b0, udf_set_i = 1'b0;
  logic [7:0] prdata, tdr_o;
  logic       pready, pslverr, load_o, dir_o, en_o;
  logic [1:0] cks_o;

  timer_apb_slave #(.WAIT_CYCLES(WAIT), .ADDR_W(8)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tcnt_i(tcnt_i),
    .ovf_set_i(ovf_set_i), .udf_set_i(udf_set_i), .tdr_o(tdr_o),
    .load_o(load_o), .dir_o(dir_o), .en_o(en_o), .cks_o(cks_o)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: register contents plus "a transfer is in progress"
  logic [7:0] m_tdr = 8'h00, m_tcr = 8'h00;
  logic       m_ovf = 1'b0, m_udf = 1'b0;
  logic       cur_valid = 1'b0;
  int         acc = 0, accn;
  logic       erdy, er, clr_o, clr_u;
  logic [7:0] rv;
  bit         rnd = 0;

  // Per-cycle compare: a transfer completes WAIT+2 cycles after penable is
  // first seen (one SETUP-state cycle + WAIT waits + the ready cycle)
  always @(negedge pclk) begin
    if (preset) begin
      chk("rst_pready", pready, 8'h0);
      chk("rst_pslverr", pslverr, 8'h0);
      chk("rst_prdata", prdata, 8'h00);
      chk("rst_tdr_o", tdr_o, 8'h00);
      chk("rst_ctl", {load_o, dir_o, en_o, cks_o}, 8'h00);
      m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; acc = 0;
    end else begin
      accn = (cur_valid && psel && penable) ? acc + 1 : 0;
      erdy = (accn == WAIT + 2);
      er   = (paddr > 8'h03) || (pwrite && paddr == 8'h03);
      case (paddr)
        8'h00:   rv = m_tdr;
        8'h01:   rv = m_tcr;
        8'h02:   rv = {6'b0, m_udf, m_ovf};
        8'h03:   rv = tcnt_i;
        default: rv = 8'h00;
      endcase
      chk("pready", pready, 8'(erdy));
      chk("pslverr", pslverr, 8'(erdy && er));
      chk("prdata", prdata, (erdy && !pwrite && !er) ? rv : 8'h00);
      chk("tdr_o", tdr_o, m_tdr);
      chk("load_o", load_o, 8'(m_tcr[7]));
      chk("dir_o", dir_o, 8'(m_tcr[5]));
      chk("en_o", en_o, 8'(m_tcr[4]));
      chk("cks_o", cks_o, 8'(m_tcr[1:0]));
      clr_o = 1'b0; clr_u = 1'b0;
      if (erdy && pwrite && !er) begin
        if (paddr == 8'h00) m_tdr = pwdata;
        if (paddr == 8'h01) m_tcr = pwdata & 8'hB3;
        if (paddr == 8'h02) begin clr_o = !pwdata[0]; clr_u = !pwdata[1]; end
      end
      m_ovf = ovf_set_i | (m_ovf & !clr_o);
      m_udf = udf_set_i | (m_udf & !clr_u);
      acc = accn;
    end
  end

  // Side-band inputs for one cycle (random in the soak phase)
  task automatic side();
    if (rnd) begin
      ovf_set_i = ($urandom % 6 == 0);
      udf_set_i = ($urandom % 6 == 0);
      tcnt_i    = 8'($urandom);
    end else begin
      ovf_set_i = 1'b0;
      udf_set_i = 1'b0;
    end
  endtask

  logic [7:0] x_rd;
  logic       x_err;
  int         x_lat;

  // One complete APB transfer; optional udf pulse lands in the ready cycle
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input bit udf_hit);
    bit got = 0;
    x_rd = 8'hxx; x_err = 1'bx; x_lat = -1;
    @(posedge pclk); #1;
    side();
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    side();
    penable = 1'b1; cur_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge pclk);
      if (pready) begin
        got = 1; x_rd = prdata; x_err = pslverr; x_lat = k;
        break;
      end
      @(posedge pclk); #1;
      side();
      if (udf_hit && (k + 1 == WAIT + 1)) udf_set_i = 1'b1;
    end
    @(posedge pclk); #1;
    side();
    psel = 1'b0; penable = 1'b0; cur_valid = 1'b0;
    chk("xfer_timeout", 8'(got), 8'h1);
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp,
                    input logic exp_err);
    xfer(1'b0, a, 8'h00, 0);
    chk(nm, x_rd, exp);
    chk({nm, "_err"}, 8'(x_err), 8'(exp_err));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    xfer(1'b1, a, d, 0);
  endtask

  task automatic pulse(input bit o, input bit u);
    @(posedge pclk); #1; ovf_set_i = o; udf_set_i = u;
    @(posedge pclk); #1; ovf_set_i = 1'b0; udf_set_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset values
    rd("rst_tdr", 8'h00, 8'h00, 1'b0);
    chk("lat_wait2", 8'(x_lat), 8'(WAIT + 1));
    rd("rst_tcr", 8'h01, 8'h00, 1'b0);
    rd("rst_tsr", 8'h02, 8'h00, 1'b0);

    // Control registers
    wr(8'h00, 8'hA5);
    chk("tdr_a5", tdr_o, 8'hA5);
    wr(8'h01, 8'h80);
    chk("load_hi", 8'(load_o), 8'h1);
    wr(8'h01, 8'h10);
    chk("load_lo", 8'(load_o), 8'h0);
    chk("en_hi", 8'(en_o), 8'h1);
    chk("dir_up", 8'(dir_o), 8'h0);
    rd("tcr_10", 8'h01, 8'h10, 1'b0);
    wr(8'h01, 8'hFF);
    rd("tcr_b3", 8'h01, 8'hB3, 1'b0);
    chk("cks_3", 8'(cks_o), 8'h3);

    // Status flags
    pulse(1, 0);
    pulse(0, 1);
    rd("tsr_03", 8'h02, 8'h03, 1'b0);
    wr(8'h02, 8'h01);
    rd("tsr_01", 8'h02, 8'h01, 1'b0);
    wr(8'h02, 8'h00);
    rd("tsr_00", 8'h02, 8'h00, 1'b0);
    pulse(1, 0);
    xfer(1'b1, 8'h02, 8'h00, 1);
    rd("tsr_setwins", 8'h02, 8'h02, 1'b0);

    // Error responses and TCNT
    xfer(1'b1, 8'h03, 8'h77, 0);
    chk("wr_tcnt_err", 8'(x_err), 8'h1);
    rd("rd_07", 8'h07, 8'h00, 1'b1);
    rd("tdr_kept", 8'h00, 8'hA5, 1'b0);
    tcnt_i = 8'h38;
    rd("tcnt_38", 8'h03, 8'h38, 1'b0);

    // Reset in the middle of ACCESS of a TDR=0x55 write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
    @(posedge pclk); #1; penable = 1'b1; cur_valid = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1; psel = 1'b0; penable = 1'b0; cur_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    chk("abort_tdr", tdr_o, 8'h00);
    wr(8'h00, 8'h3C);
    chk("post_rst_lat", 8'(x_lat), 8'(WAIT + 1));
    rd("tdr_3c", 8'h00, 8'h3C, 1'b0);

    // penable without setup, then psel dropped mid-ACCESS: neither commits
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    repeat (3) @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; pwdata = 8'hDD;
    @(posedge pclk); #1; penable = 1'b1; cur_valid = 1'b1;
    repeat (2) @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0; cur_valid = 1'b0;
    rd("tdr_noabort", 8'h00, 8'h3C, 1'b0);

    // Randomized soak against the model
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      xfer(1'($urandom), ($urandom % 5 == 0) ? 8'($urandom) : 8'($urandom % 4),
           8'($urandom), 0);
      if ($urandom % 4 == 0) begin
        @(posedge pclk); #1; side();
      end
    end
    rnd = 0;
    @(posedge pclk); #1; side();
    repeat (2) @(posedge pclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
